// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write-channel controller: one burst at a time, FIXED/INCR/WRAP beat addressing, single B response.
// Define AXI4_WRITE_CTRL_4KB_CHECK_EN to reject INCR bursts that cross a 4 KB boundary.
module axi4_slave_write_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t state, state_next;

  // run_q keeps awready low while areset is high; the FSM itself resets to IDLE.
  logic                     run_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [7:0]               len_q;
  logic [7:0]               cnt_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic                     aw_err_q;
  logic                     wlast_err_q;

  logic aw_hs, w_hs, last_beat, aw_err_in, cross_4k;
  logic [ADDRESS_WIDTH-1:0] bytes, aligned, incr_addr, wrap_size, wrap_lower, addr_next;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign last_beat = (cnt_q == len_q);

  assign aw_err_in = (awburst == BURST_RSVD)
                   || (int'(awsize) > MAX_SIZE)
                   || ((awburst == BURST_WRAP) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

`ifdef AXI4_WRITE_CTRL_4KB_CHECK_EN
  logic [11:0] aw_offset;
  logic [16:0] aw_span;
  logic [17:0] aw_end;

  assign aw_offset = awaddr[11:0] & ~((12'd1 << awsize) - 12'd1);
  assign aw_span   = ({9'd0, awlen} + 17'd1) << awsize;
  assign aw_end    = {6'd0, aw_offset} + {1'b0, aw_span};
  assign cross_4k  = (awburst == BURST_INCR) && (aw_end > 18'd4096);
`else
  assign cross_4k  = 1'b0;
`endif

  // Next beat address; INCR aligns after the first (possibly unaligned) beat.
  assign bytes      = ADDRESS_WIDTH'(1) << size_q;
  assign aligned    = addr_q & ~(bytes - ADDRESS_WIDTH'(1));
  assign incr_addr  = aligned + bytes;
  assign wrap_size  = ADDRESS_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
  assign wrap_lower = addr_q & ~(wrap_size - ADDRESS_WIDTH'(1));

  always_comb begin
    unique case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (incr_addr == wrap_lower + wrap_size) ? wrap_lower : incr_addr;
      default:     addr_next = incr_addr;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    unique case (state)
      IDLE: begin
        awready = run_q;
        if (awvalid && run_q) state_next = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_next = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_q       <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      aw_err_q    <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (aw_hs) begin
        id_q        <= awid;
        addr_q      <= awaddr;
        len_q       <= awlen;
        size_q      <= awsize;
        burst_q     <= awburst;
        cnt_q       <= '0;
        aw_err_q    <= aw_err_in | cross_4k;
        wlast_err_q <= 1'b0;
      end
      if (w_hs) begin
        addr_q <= addr_next;
        // Holding on the last beat keeps len = 255 from wrapping the counter.
        if (!last_beat)         cnt_q       <= cnt_q + 8'd1;
        if (wlast != last_beat) wlast_err_q <= 1'b1;
      end
    end
  end

  assign bid       = id_q;
  assign bresp     = (bvalid && (aw_err_q || wlast_err_q)) ? RESP_SLVERR : RESP_OKAY;
  assign mem_wr_en = w_hs & ~aw_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

endmodule

// File: doc/axi4_slave_write_ctrl.md
# axi4_slave_write_ctrl

Slave-side AXI4 write-channel controller. It accepts one write burst at a time on AW, sequences the W beats onto a simple byte-strobed memory write port, and returns a single B response. It generates per-beat addresses for FIXED, INCR and WRAP bursts and checks burst legality. It sits between the slave agent's pin-level AXI4 write channels and the slave memory model.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; must be 8·2^n
- ID_WIDTH, 16, AWID/BID width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid  in  ID_WIDTH  write address ID
- awaddr  in  ADDRESS_WIDTH  start address
- awlen  in  8  beats minus 1
- awsize  in  3  bytes per beat = 2^awsize
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  last beat marker
- wvalid / wready  in / out  1  W handshake
- bid  out  ID_WIDTH  response ID, equal to the latched awid
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid / bready  out / in  1  B handshake
- mem_wr_en  out  1  write strobe, one cycle per accepted beat
- mem_addr  out  ADDRESS_WIDTH  current beat address
- mem_wdata  out  DATA_WIDTH  wdata passthrough
- mem_wstrb  out  DATA_WIDTH/8  wstrb passthrough

## Operation
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- IDLE:
  - awready = 1.
  - On awvalid&awready, latch id, addr, len, size and burst; clear the beat counter and the error flag.
  - Evaluate the AW errors: burst == 11; awsize > log2(DATA_WIDTH/8); WRAP with awlen not in {1,3,7,15}.
  - Go to DATA.
- DATA:
  - wready = 1.
  - Each W handshake is one beat. mem_wr_en = wvalid & wready & ~aw_err. mem_addr = beat address register.
  - Beat counter increments per beat (8-bit).
  - A beat with wlast and count ≠ len, or without wlast and count == len, sets wlast_err. The write is still performed.
  - On the beat with count == len, go to RESP.
- Next-address rules, with bytes = 2^size:
  - FIXED: the address is held.
  - INCR: next = (addr & ~(bytes−1)) + bytes. The first beat uses the unaligned awaddr. The address wraps modulo 2^ADDRESS_WIDTH.
  - WRAP: wsize = (len+1)·bytes and lower = addr & ~(wsize−1). If next == lower+wsize, the address returns to lower.
- RESP:
  - bvalid = 1; bid = latched id.
  - bresp = SLVERR if any error flag is set, else OKAY.
  - On bready, go to IDLE.
- Only one burst is outstanding at a time. awready stays 0 outside IDLE.

## Timing
- While areset is high, all outputs are 0 (awready, wready, bvalid, mem_wr_en, bresp, bid, mem_addr). awready rises at the first edge after release.
- awready, wready and bvalid are decoded from the registered state. Handshakes complete in the cycle both signals are high.
- mem_wr_en is combinational in the beat cycle: zero latency from the W handshake.
- Minimum burst length is 1 + (len+1) + 1 cycles: AW cycle, beat cycles, B cycle. The next AW is accepted the cycle after the B handshake.
- W beats presented before the AW handshake are not accepted (wready = 0).
- Reset asserted mid-burst returns the FSM to IDLE immediately and discards the burst. No B response is produced.
- len = 255 is legal for INCR. The counter must not overflow before the transition to RESP.

## Configuration
- AXI4_WRITE_CTRL_4KB_CHECK_EN defined:
  - An INCR burst whose last byte address crosses a 4 KB boundary, i.e. (awaddr & 0xFFF) + (len+1)·bytes > 4096 using aligned start, sets aw_err.
  - All mem_wr_en for that burst are suppressed and bresp = SLVERR.
- Not defined: no boundary check. Addresses increment and wrap modulo 2^ADDRESS_WIDTH.

## Test plan
- INCR, awaddr 0x100, len 3, size 2, wlast on beat 3 → mem_addr 0x100, 0x104, 0x108, 0x10C; 4 mem_wr_en pulses; bresp 00; bid = awid.
- WRAP, awaddr 0x38, len 3, size 2 → mem_addr 0x38, 0x3C, 0x30, 0x34; bresp 00.
- FIXED, awaddr 0x20, len 2 → mem_addr 0x20 three times; hold bready low 5 cycles and check bvalid stays 1 and awready stays 0.
- Error cases:
  - awburst 11 → no mem_wr_en, bresp 10.
  - WRAP len 2 → bresp 10.
  - INCR len 3 with wlast on beat 1 → 4 writes, bresp 10.
- Assert areset during beat 2 of a len-7 burst → next cycle all outputs 0; after release, a new len-0 burst completes with bresp 00.
- With AXI4_WRITE_CTRL_4KB_CHECK_EN, INCR awaddr 0xFF8, len 3, size 2 → no writes, bresp 10. Without the macro → 4 writes ending at 0x1004, bresp 00.
